tb_ctrl: RTL

Traceback controller for the 4-state (K=3) Viterbi decoder. It gates decision-bit writes from the ACS stage into the 8-deep traceback path memory, then stalls the ACS stage while it walks the stored decisions back from a start state. Recovered bits are emitted in chronological order over a valid/ready stream. It sits between the ACS/path-metric stage and the decoder output.

---
 rtl/tb_ctrl_pkg.sv | 27 ++
 rtl/tb_ctrl_if.sv | 58 +++++
 rtl/tb_ctrl_step.sv | 24 ++
 rtl/tb_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/tb_ctrl_pkg.sv
// Shared definitions for the K=3 Viterbi traceback controller.
//   - DEPTH_DEF      : default traceback length (trellis steps).
//   - trellis_state_t: 2-bit trellis state {u_t, u_t-1}.
//   - dec_vec_t      : one decision bit per trellis state, indexed by state.
//   - tb_fsm_e       : controller phases FILL / TRACE / EMIT.
//   - pred_state()   : predecessor of a state given its decision bit.
package tb_ctrl_pkg;

  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned NUM_STATES = 4;
  localparam int unsigned STATE_W    = 2;

  typedef logic [STATE_W-1:0]    trellis_state_t;
  typedef logic [NUM_STATES-1:0] dec_vec_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2
  } tb_fsm_e;

  // Shift the older input bit up and append the survivor decision.
  function automatic trellis_state_t pred_state(input trellis_state_t s, input logic d);
    return {s[0], d};
  endfunction

endpackage

// File: rtl/tb_ctrl_if.sv
// Bus bundle between the ACS stage / path memory, the traceback controller
// and the decoded-bit consumer.
//   ACS side   : in_valid, in_ready, best_state, tbpm_we
//   Path memory: sel00_i .. sel11_i (bit DEPTH-1 is the newest decision)
//   Output side: out_bit, out_valid, out_ready, out_last
// Modports:
//   master : environment (ACS stage, path memory, downstream sink)
//   slave  : traceback controller
interface tb_ctrl_if #(
  parameter int unsigned DEPTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       best_state;
  logic             tbpm_we;

  logic [DEPTH-1:0] sel00_i;
  logic [DEPTH-1:0] sel01_i;
  logic [DEPTH-1:0] sel10_i;
  logic [DEPTH-1:0] sel11_i;

  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output in_valid,
    output best_state,
    output sel00_i,
    output sel01_i,
    output sel10_i,
    output sel11_i,
    output out_ready,
    input  in_ready,
    input  tbpm_we,
    input  out_bit,
    input  out_valid,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  best_state,
    input  sel00_i,
    input  sel01_i,
    input  sel10_i,
    input  sel11_i,
    input  out_ready,
    output in_ready,
    output tbpm_we,
    output out_bit,
    output out_valid,
    output out_last
  );

endinterface

// File: rtl/tb_ctrl_step.sv
// Single traceback step (tb_step function): from the current trellis state and
// the four decision bits of one trellis step, produce the predecessor state
// and the decoded bit. Purely combinational so it can be reused by a
// sliding-window traceback.
//   i_cur_state    : current trellis state {u_t, u_t-1}
//   i_dec          : decision bit of each state at this step, indexed by state
//   o_prev_state_c : predecessor state {cur_state[0], d}
//   o_dec_bit_c    : decoded bit u_t = cur_state[1]
module tb_ctrl_step
  import tb_ctrl_pkg::*;
(
  input  trellis_state_t i_cur_state,
  input  dec_vec_t       i_dec,
  output trellis_state_t o_prev_state_c,
  output logic           o_dec_bit_c
);

  logic w_d;

  assign w_d            = i_dec[i_cur_state];
  assign o_prev_state_c = pred_state(i_cur_state, w_d);
  assign o_dec_bit_c    = i_cur_state[1];

endmodule

// File: rtl/tb_ctrl.sv
// Traceback controller for the 4-state (K=3) Viterbi decoder.
// Gates decision writes into the DEPTH-deep path memory (FILL), then stalls
// the ACS stage while walking the stored decisions back from the start state
// (TRACE), then streams the recovered bits oldest-first (EMIT).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tb_ctrl_if slave (ACS handshake, path memory taps, output stream)
//   busy     : high while in TRACE or EMIT
module tb_ctrl
  import tb_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter bit          TERM_ZERO = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  tb_ctrl_if.slave bus,
  output logic     busy
);

  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  tb_fsm_e          r_state;
  logic [CW-1:0]    r_step_cnt;
  logic [CW-1:0]    r_emit_cnt;
  trellis_state_t   r_cur_state;
  logic [DEPTH-1:0] r_dec_buf;

  tb_fsm_e          w_state_nxt;
  logic [CW-1:0]    w_step_cnt_nxt;
  logic [CW-1:0]    w_emit_cnt_nxt;
  trellis_state_t   w_cur_state_nxt;
  logic [DEPTH-1:0] w_dec_buf_nxt;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  logic [IDXW-1:0]  w_tb_idx;
  logic [IDXW-1:0]  w_emit_idx;
  dec_vec_t         w_step_dec;
  trellis_state_t   w_prev_state;
  logic             w_dec_bit;

  // TRACE step k reads the decision column DEPTH-1-k (newest first).
  assign w_tb_idx   = IDXW'(DEPTH - 1) - r_step_cnt[IDXW-1:0];
  assign w_emit_idx = r_emit_cnt[IDXW-1:0];

  assign w_step_dec = {bus.sel11_i[w_tb_idx], bus.sel10_i[w_tb_idx],
                       bus.sel01_i[w_tb_idx], bus.sel00_i[w_tb_idx]};

  tb_ctrl_step u_step (
    .i_cur_state    (r_cur_state),
    .i_dec          (w_step_dec),
    .o_prev_state_c (w_prev_state),
    .o_dec_bit_c    (w_dec_bit)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath next values and state-decoded outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_step_cnt_nxt  = r_step_cnt;
    w_emit_cnt_nxt  = r_emit_cnt;
    w_cur_state_nxt = r_cur_state;
    w_dec_buf_nxt   = r_dec_buf;
    w_in_ready      = 1'b0;
    w_out_valid     = 1'b0;
    w_busy          = 1'b0;

    case (r_state)
      FILL: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          if (r_step_cnt == LAST_CNT) begin
            w_step_cnt_nxt  = '0;
            w_cur_state_nxt = TERM_ZERO ? trellis_state_t'(2'b00)
                                        : trellis_state_t'(bus.best_state);
            w_state_nxt     = TRACE;
          end else begin
            w_step_cnt_nxt = r_step_cnt + CW'(1);
          end
        end
      end

      TRACE: begin
        w_busy                  = 1'b1;
        w_dec_buf_nxt[w_tb_idx] = w_dec_bit;
        w_cur_state_nxt         = w_prev_state;
        if (r_step_cnt == LAST_CNT) begin
          w_step_cnt_nxt = '0;
          w_emit_cnt_nxt = '0;
          w_state_nxt    = EMIT;
        end else begin
          w_step_cnt_nxt = r_step_cnt + CW'(1);
        end
      end

      EMIT: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          if (r_emit_cnt == LAST_CNT) begin
            w_emit_cnt_nxt = '0;
            w_state_nxt    = FILL;
          end else begin
            w_emit_cnt_nxt = r_emit_cnt + CW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // Counters, traceback state and decoded-bit buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_cnt  <= '0;
      r_emit_cnt  <= '0;
      r_cur_state <= '0;
      r_dec_buf   <= '0;
    end else begin
      r_step_cnt  <= w_step_cnt_nxt;
      r_emit_cnt  <= w_emit_cnt_nxt;
      r_cur_state <= w_cur_state_nxt;
      r_dec_buf   <= w_dec_buf_nxt;
    end
  end

  // Output bit is forced low outside EMIT so stale buffer data never leaks.
  assign bus.in_ready  = w_in_ready;
  assign bus.tbpm_we   = bus.in_valid & w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_bit   = w_out_valid & r_dec_buf[w_emit_idx];
  assign bus.out_last  = w_out_valid & (r_emit_cnt == LAST_CNT);
  assign busy          = w_busy;

endmodule
